instr_encode_loader: RTL and testbench



---
 rtl/instr_encode_loader_pkg.sv | 55 +++++
 rtl/instr_encode_loader_pack.sv | 42 ++++
 rtl/instr_encode_loader.sv | 132 +++++++++++++
 tb/tb_instr_encode_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encode_loader_pkg.sv
// Shared encoding for the instruction encoder/decoder pair: field widths, field
// positions, opcode constants and the opcode -> format-class map.
package instr_encode_loader_pkg;

   localparam int INSTRUCTION_WIDTH = 33;
   localparam int WIDTH_OPCODE      = 5;
   localparam int REGFILE_ADDR_BITS = 4;
   localparam int IMMEDIATE_WIDTH   = 16;
   localparam int IMEM_ADDR_BITS    = 8;

   localparam int OPCODE_LSB = 28;
   localparam int DEST_LSB   = 24;
   localparam int SRC1_LSB   = 20;
   localparam int SRC2_LSB   = 16;
   localparam int IMM_LSB    = 0;

   localparam logic [WIDTH_OPCODE-1:0] INSTR_NOP  = 5'h00;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_MOVE = 5'h01;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_LI   = 5'h02;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_LR   = 5'h03;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_SR   = 5'h04;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_ADD  = 5'h05;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_ADDI = 5'h06;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_SUB  = 5'h07;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_AND  = 5'h08;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_OR   = 5'h09;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_NOT  = 5'h0A;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_SHL  = 5'h0B;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_SHR  = 5'h0C;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_BE   = 5'h0D;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_BNE  = 5'h0E;
   localparam logic [WIDTH_OPCODE-1:0] INSTR_CMP  = 5'h0F;

   typedef enum logic [2:0] {
      FMT_NOP, FMT_R3, FMT_RI, FMT_LI, FMT_R2, FMT_CMP, FMT_ILLEGAL
   } fmt_t;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FULL} load_state_t;

   function automatic fmt_t fmt_of(input logic [WIDTH_OPCODE-1:0] op);
      fmt_t f;
      case (op)
         INSTR_NOP:                                   f = FMT_NOP;
         INSTR_ADD, INSTR_SUB, INSTR_AND, INSTR_OR:   f = FMT_R3;
         INSTR_LR, INSTR_SR, INSTR_ADDI, INSTR_SHL,
         INSTR_SHR, INSTR_BE, INSTR_BNE:              f = FMT_RI;
         INSTR_LI:                                    f = FMT_LI;
         INSTR_MOVE, INSTR_NOT:                       f = FMT_R2;
         INSTR_CMP:                                   f = FMT_CMP;
         default:                                     f = FMT_ILLEGAL;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/instr_encode_loader_pack.sv
// Combinational packer: classifies the opcode and places only the fields that
// its format uses into the machine word; everything else is forced to zero.
module instr_pack
   import instr_encode_loader_pkg::*;
(
   input  logic [WIDTH_OPCODE-1:0]      opcode,
   input  logic [REGFILE_ADDR_BITS-1:0] dest,
   input  logic [REGFILE_ADDR_BITS-1:0] src1,
   input  logic [REGFILE_ADDR_BITS-1:0] src2,
   input  logic [IMMEDIATE_WIDTH-1:0]   imm,
   output logic [INSTRUCTION_WIDTH-1:0] word,
   output logic                         legal
);

   fmt_t fmt;
   logic use_dest, use_src1, use_src2, use_imm;

   always_comb begin
      fmt      = fmt_of(opcode);
      use_dest = 1'b0;
      use_src1 = 1'b0;
      use_src2 = 1'b0;
      use_imm  = 1'b0;
      case (fmt)
         FMT_R3:  begin use_dest = 1'b1; use_src1 = 1'b1; use_src2 = 1'b1; end
         FMT_RI:  begin use_dest = 1'b1; use_src1 = 1'b1; use_imm  = 1'b1; end
         FMT_LI:  begin use_dest = 1'b1; use_imm  = 1'b1; end
         FMT_R2:  begin use_dest = 1'b1; use_src1 = 1'b1; end
         FMT_CMP: begin use_src1 = 1'b1; use_src2 = 1'b1; end
         default: ;
      endcase

      word = '0;
      word[OPCODE_LSB +: WIDTH_OPCODE] = opcode;
      if (use_dest) word[DEST_LSB +: REGFILE_ADDR_BITS] = dest;
      if (use_src1) word[SRC1_LSB +: REGFILE_ADDR_BITS] = src1;
      if (use_src2) word[SRC2_LSB +: REGFILE_ADDR_BITS] = src2;
      if (use_imm)  word[IMM_LSB  +: IMMEDIATE_WIDTH]   = imm;
      legal = (fmt != FMT_ILLEGAL);
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts instruction fields, packs them and writes them to
// consecutive instruction-memory addresses. INSTR_LOADER_CHECKSUM_EN adds a running XOR output.
module instr_encode_loader
   import instr_encode_loader_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [IMEM_ADDR_BITS-1:0]    base_addr,
   input  logic                         finish,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH_OPCODE-1:0]      in_opcode,
   input  logic [REGFILE_ADDR_BITS-1:0] in_dest,
   input  logic [REGFILE_ADDR_BITS-1:0] in_src1,
   input  logic [REGFILE_ADDR_BITS-1:0] in_src2,
   input  logic [IMMEDIATE_WIDTH-1:0]   in_imm,
   output logic                         mem_we,
   output logic [IMEM_ADDR_BITS-1:0]    mem_addr,
   output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
   output logic [IMEM_ADDR_BITS:0]      word_count,
   output logic                         busy,
   output logic                         full,
   output logic                         err_illegal
`ifdef INSTR_LOADER_CHECKSUM_EN
   ,
   output logic [INSTRUCTION_WIDTH-1:0] checksum
`endif
);

   localparam logic [IMEM_ADDR_BITS-1:0] TOP_ADDR  = '1;
   localparam logic [IMEM_ADDR_BITS:0]   COUNT_ONE = {{IMEM_ADDR_BITS{1'b0}}, 1'b1};

   load_state_t                  state_reg, state_next;
   logic [IMEM_ADDR_BITS-1:0]    addr_reg, mem_addr_reg, wr_addr;
   logic [IMEM_ADDR_BITS:0]      count_reg;
   logic                         mem_we_reg, full_reg, err_reg;
   logic [INSTRUCTION_WIDTH-1:0] mem_wdata_reg, pack_word;
   logic                         pack_legal, top_pending, xfer;

   instr_pack u_pack (
      .opcode (in_opcode),
      .dest   (in_dest),
      .src1   (in_src1),
      .src2   (in_src2),
      .imm    (in_imm),
      .word   (pack_word),
      .legal  (pack_legal)
   );

   // A write to the top address in flight means the next word has nowhere to go.
   assign top_pending = mem_we_reg && (mem_addr_reg == TOP_ADDR);
   // Restart also blocks acceptance so a word can never land at a stale address.
   assign in_ready    = (state_reg == ST_LOAD) && !finish && !start && !top_pending;
   assign xfer        = in_valid && in_ready;
   // addr_reg only catches up at the end of the write cycle, so look ahead past it.
   assign wr_addr     = mem_we_reg ? mem_addr_reg + 1'b1 : addr_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_LOAD;
         ST_LOAD: begin
            if (start)            state_next = ST_LOAD;
            else if (finish)      state_next = ST_IDLE;
            else if (top_pending) state_next = ST_FULL;
         end
         ST_FULL: begin
            if (start)       state_next = ST_LOAD;
            else if (finish) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         addr_reg      <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         mem_we_reg <= xfer && pack_legal;
         if (xfer && pack_legal) begin
            mem_addr_reg  <= wr_addr;
            mem_wdata_reg <= pack_word;
         end
         if (start) begin
            addr_reg  <= base_addr;
            count_reg <= '0;
            full_reg  <= 1'b0;
            err_reg   <= 1'b0;
         end else begin
            if (mem_we_reg) begin
               count_reg <= count_reg + COUNT_ONE;
               if (top_pending) full_reg <= 1'b1;
               else             addr_reg <= mem_addr_reg + 1'b1;
            end
            if (xfer && !pack_legal) err_reg <= 1'b1;
         end
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [INSTRUCTION_WIDTH-1:0] checksum_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          checksum_reg <= '0;
      else if (start)      checksum_reg <= '0;
      else if (mem_we_reg) checksum_reg <= checksum_reg ^ mem_wdata_reg;
   end

   assign checksum = checksum_reg;
`endif

   assign mem_we      = mem_we_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_wdata   = mem_wdata_reg;
   assign word_count  = count_reg;
   assign busy        = (state_reg == ST_LOAD);
   assign full        = full_reg;
   assign err_illegal = err_reg;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: expected writes are queued when a
// word is accepted and popped by a monitor when mem_we is seen.
module tb_instr_encode_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  base_addr;
   logic        finish;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_opcode;
   logic [3:0]  in_dest;
   logic [3:0]  in_src1;
   logic [3:0]  in_src2;
   logic [15:0] in_imm;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [32:0] mem_wdata;
   logic [8:0]  word_count;
   logic        busy;
   logic        full;
   logic        err_illegal;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [32:0] checksum;
`endif

   instr_encode_loader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .finish      (finish),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_opcode   (in_opcode),
      .in_dest     (in_dest),
      .in_src1     (in_src1),
      .in_src2     (in_src2),
      .in_imm      (in_imm),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .word_count  (word_count),
      .busy        (busy),
      .full        (full),
      .err_illegal (err_illegal)
`ifdef INSTR_LOADER_CHECKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   typedef struct {
      logic [7:0]  addr;
      logic [32:0] data;
      int          cyc;
   } sb_t;

   sb_t        sb_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc   = 0;
   logic [7:0] exp_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         if (sb_q.size() == 0) begin
            check("unexpected_we", 64'(mem_we), 64'd0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            $display("write addr=0x%02h data=0x%09h cyc=%0d", mem_addr, mem_wdata, cyc);
            check("wr_addr",  64'(mem_addr),  64'(e.addr));
            check("wr_data",  64'(mem_wdata), 64'(e.data));
            check("wr_cycle", 64'(cyc),       64'(e.cyc));
         end
      end
   end

   task automatic do_start(input logic [7:0] base);
      start     = 1'b1;
      base_addr = base;
      exp_addr  = base;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic do_finish();
      finish = 1'b1;
      @(posedge clk); #1;
      finish = 1'b0;
   endtask

   task automatic set_fields(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [15:0] imm);
      in_opcode = op;
      in_dest   = d;
      in_src1   = s1;
      in_src2   = s2;
      in_imm    = imm;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
   task automatic send(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [15:0] imm,
                       input logic legal, input logic [32:0] exp_word);
      int guard;
      set_fields(op, d, s1, s2, imm);
      in_valid = 1'b1;
      guard    = 0;
      #1;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #2;
         guard++;
      end
      if (!in_ready) begin
         check("send_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      if (legal) begin
         sb_q.push_back('{addr: exp_addr, data: exp_word, cyc: cyc + 1});
         exp_addr = exp_addr + 8'd1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; finish = 1'b0; in_valid = 1'b0;
      set_fields(5'h0, 4'h0, 4'h0, 4'h0, 16'h0);
      exp_addr = '0;
      @(posedge clk); #1;
      check("rst_mem_we",     64'(mem_we),      64'd0);
      check("rst_mem_addr",   64'(mem_addr),    64'd0);
      check("rst_mem_wdata",  64'(mem_wdata),   64'd0);
      check("rst_word_count", 64'(word_count),  64'd0);
      check("rst_busy",       64'(busy),        64'd0);
      check("rst_full",       64'(full),        64'd0);
      check("rst_err",        64'(err_illegal), 64'd0);
      check("rst_in_ready",   64'(in_ready),    64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Sum loop program, back to back from address 0
      do_start(8'h00);
      check("sum_busy", 64'(busy), 64'd1);
      send(5'h02, 4'd1, 4'd0, 4'd0, 16'h0000, 1'b1, 33'h021000000);
      send(5'h02, 4'd2, 4'd0, 4'd0, 16'h0000, 1'b1, 33'h022000000);
      send(5'h02, 4'd3, 4'd0, 4'd0, 16'h000A, 1'b1, 33'h02300000A);
      send(5'h05, 4'd2, 4'd2, 4'd1, 16'h0000, 1'b1, 33'h052210000);
      send(5'h06, 4'd1, 4'd1, 4'd0, 16'h0001, 1'b1, 33'h061100001);
      send(5'h0E, 4'd1, 4'd3, 4'd0, 16'hFFFD, 1'b1, 33'h0E130FFFD);
      @(posedge clk); #1;
      check("sum_word_count", 64'(word_count), 64'd6);
`ifdef INSTR_LOADER_CHECKSUM_EN
      check("sum_checksum", 64'(checksum),
            64'(33'h021000000 ^ 33'h022000000 ^ 33'h02300000A ^
                33'h052210000 ^ 33'h061100001 ^ 33'h0E130FFFD));
`endif

      // Unused fields must be masked per format
      send(5'h05, 4'd3, 4'd1, 4'd2, 16'hFFFF, 1'b1, 33'h053120000);
      send(5'h02, 4'd1, 4'd5, 4'd7, 16'h0010, 1'b1, 33'h021000010);
      send(5'h0F, 4'd7, 4'd2, 4'd3, 16'h0055, 1'b1, 33'h0F0230000);
      send(5'h00, 4'd9, 4'd9, 4'd9, 16'hABCD, 1'b1, 33'h000000000);
      do_finish();
      check("mask_busy", 64'(busy), 64'd0);
      check("mask_word_count", 64'(word_count), 64'd10);

      // Illegal opcode mid-stream
      do_start(8'h00);
      send(5'h02, 4'd1, 4'd0, 4'd0, 16'h0000, 1'b1, 33'h021000000);
      send(5'h05, 4'd2, 4'd2, 4'd1, 16'h0000, 1'b1, 33'h052210000);
      send(5'h1F, 4'd1, 4'd1, 4'd1, 16'h1111, 1'b0, 33'h0);
      check("ill_err_set", 64'(err_illegal), 64'd1);
      send(5'h02, 4'd3, 4'd0, 4'd0, 16'h000A, 1'b1, 33'h02300000A);
      @(posedge clk); #1;
      check("ill_word_count", 64'(word_count), 64'd3);
      check("ill_err_sticky", 64'(err_illegal), 64'd1);
      do_start(8'h40);
      check("ill_err_clr", 64'(err_illegal), 64'd0);
      check("ill_count_clr", 64'(word_count), 64'd0);
      do_finish();

      // Fill to the top of memory
      do_start(8'hFE);
      send(5'h07, 4'd1, 4'd2, 4'd3, 16'h7777, 1'b1, 33'h071230000);
      send(5'h0B, 4'd4, 4'd5, 4'd6, 16'h0003, 1'b1, 33'h0B4500003);
      set_fields(5'h02, 4'd1, 4'd0, 4'd0, 16'h0001);
      in_valid = 1'b1;
      #1;
      check("fill_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check("fill_full", 64'(full), 64'd1);
      check("fill_busy", 64'(busy), 64'd0);
      check("fill_word_count", 64'(word_count), 64'd2);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("fill_ready_hold", 64'(in_ready), 64'd0);
      end
      check("fill_no_wrap", 64'(mem_addr), 64'hFF);
      in_valid = 1'b0;
      do_finish();
      check("fill_idle", 64'(busy), 64'd0);

      // Finish with valid held, the pending write still completes
      do_start(8'h10);
      send(5'h01, 4'd5, 4'd6, 4'd9, 16'h1234, 1'b1, 33'h015600000);
      set_fields(5'h02, 4'd2, 4'd0, 4'd0, 16'h0002);
      in_valid = 1'b1;
      finish   = 1'b1;
      #1;
      check("fin_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      finish = 1'b0;
      check("fin_busy", 64'(busy), 64'd0);
      check("fin_ready_idle", 64'(in_ready), 64'd0);
      check("fin_word_count", 64'(word_count), 64'd1);
      in_valid = 1'b0;

      // Async reset between a transfer and its write
      do_start(8'h20);
      set_fields(5'h02, 4'd4, 4'd0, 4'd0, 16'h1234);
      in_valid = 1'b1;
      #1;
      check("ar_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("ar_pending_we", 64'(mem_we), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_we_drop", 64'(mem_we),     64'd0);
      check("ar_addr_zero", 64'(mem_addr), 64'd0);
      check("ar_data_zero", 64'(mem_wdata), 64'd0);
      check("ar_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("ar_we_stays", 64'(mem_we), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
